// File: rtl/awg_sweep_ctrl.sv
// Frequency-sweep sequencer for the DDS sine generator: steps the phase
// increment from start to stop, holding each point for a programmable dwell.
module awg_sweep_ctrl #(
    parameter int FW  = 12,
    parameter int DWW = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [FW-1:0]  cfg_start,
    input  logic [FW-1:0]  cfg_stop,
    input  logic [FW-1:0]  cfg_step,
    input  logic [DWW-1:0] cfg_dwell,
    input  logic [1:0]     cfg_mode,
    input  logic           go,
    input  logic           abort,
    output logic [FW-1:0]  state_freq,
    output logic           en,
    output logic           busy,
    output logic           sweep_done
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [FW-1:0]  start_r;
    logic [FW-1:0]  stop_r;
    logic [FW-1:0]  step_r;
    logic [DWW-1:0] dwell_r;
    logic [1:0]     mode_r;
    logic [DWW-1:0] cnt;
    logic           dir_down;

    logic launch;
    logic dwell_end;
    logic degenerate;
    logic at_top;
    logic at_bottom;
    logic is_repeat;
    logic is_tri;
    logic is_single;
    logic pass_end;
    logic finish;

    // Sums and thresholds carry one extra bit so a large step never wraps.
    function automatic logic [FW-1:0] adv_up(input logic [FW-1:0] f,
                                             input logic [FW-1:0] step,
                                             input logic [FW-1:0] lim);
        logic [FW:0] nxt;
        nxt = {1'b0, f} + {1'b0, step};
        return (nxt >= {1'b0, lim}) ? lim : nxt[FW-1:0];
    endfunction

    function automatic logic [FW-1:0] adv_down(input logic [FW-1:0] f,
                                               input logic [FW-1:0] step,
                                               input logic [FW-1:0] base);
        logic [FW:0] thr;
        thr = {1'b0, base} + {1'b0, step};
        return ({1'b0, f} < thr) ? base : f - step;
    endfunction

    assign is_repeat  = (mode_r == 2'd1);
    assign is_tri     = (mode_r == 2'd2);
    assign is_single  = !is_repeat && !is_tri;
    assign launch     = (state == IDLE) && go && !abort;
    assign dwell_end  = (state == RUN) && !abort && (cnt == dwell_r);
    assign degenerate = (start_r >= stop_r);
    assign at_top     = !dir_down && (state_freq == stop_r);
    assign at_bottom  = dir_down && (state_freq == start_r);
    // A triangle completes its cycle at the bottom turn, the other modes at stop.
    assign pass_end   = dwell_end && (degenerate || (is_tri ? at_bottom : at_top));
    assign finish     = pass_end && is_single;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (launch) state_nxt = RUN;
            RUN:     if (abort || finish) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = (state == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_r    <= '0;
            stop_r     <= '0;
            step_r     <= '0;
            dwell_r    <= '0;
            mode_r     <= '0;
            cnt        <= '0;
            dir_down   <= 1'b0;
            state_freq <= '0;
            en         <= 1'b0;
            busy       <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            sweep_done <= 1'b0;
            if (state == IDLE) begin
                if (cfg_valid) begin
                    start_r <= cfg_start;
                    stop_r  <= cfg_stop;
                    step_r  <= cfg_step;
                    dwell_r <= cfg_dwell;
                    mode_r  <= cfg_mode;
                end
                if (launch) begin
                    state_freq <= cfg_valid ? cfg_start : start_r;
                    en         <= 1'b1;
                    busy       <= 1'b1;
                    cnt        <= '0;
                    dir_down   <= 1'b0;
                end
            end else if (abort) begin
                en   <= 1'b0;
                busy <= 1'b0;
            end else if (cnt != dwell_r) begin
                cnt <= cnt + DWW'(1);
            end else begin
                cnt        <= '0;
                sweep_done <= pass_end;
                if (finish) begin
                    en   <= 1'b0;
                    busy <= 1'b0;
                end else if (degenerate) begin
                    state_freq <= start_r;
                end else if (!dir_down) begin
                    if (at_top && is_repeat) begin
                        state_freq <= start_r;
                    end else if (at_top) begin
                        dir_down   <= 1'b1;
                        state_freq <= adv_down(state_freq, step_r, start_r);
                    end else begin
                        state_freq <= adv_up(state_freq, step_r, stop_r);
                    end
                end else if (at_bottom) begin
                    dir_down   <= 1'b0;
                    state_freq <= adv_up(state_freq, step_r, stop_r);
                end else begin
                    state_freq <= adv_down(state_freq, step_r, start_r);
                end
            end
        end
    end

endmodule
